// File: rtl/camera_sensor_emulator.sv
// rtl/camera_sensor_emulator.sv - parallel camera conduit emulator generating framed test patterns
module camera_sensor_emulator #(
    parameter int          H_ACTIVE         = 640,
    parameter int          V_ACTIVE         = 480,
    parameter int          H_BLANK          = 32,
    parameter int          V_FRONT          = 16,
    parameter int          V_BLANK          = 64,
    parameter logic [15:0] FRAME_COUNT_INIT = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [11:0] camera_d,
    output logic        camera_fval,
    output logic        camera_lval,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int TMAX0 = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int TMAX  = (TMAX0 > V_BLANK) ? TMAX0 : V_BLANK;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_FRONT  = TW'(V_FRONT - 1);
    localparam logic [TW-1:0] T_HBLANK = TW'(H_BLANK - 1);
    localparam logic [TW-1:0] T_VBLANK = TW'(V_BLANK - 1);
    localparam logic [11:0]   X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0]   Y_LAST   = 12'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRONT  = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        BACK   = 3'd4,
        VBLANK = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [11:0]     x, x_n, y, y_n;
    logic [1:0]      pat_q, pat_n;
    logic [11:0]     fc_lat, fc_lat_n;
    logic [15:0]     done_cnt, done_cnt_n;
    logic            done_pulse, done_pulse_n;
    logic            start_frame;
    logic [11:0]     pix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            x          <= '0;
            y          <= '0;
            pat_q      <= '0;
            fc_lat     <= '0;
            done_cnt   <= FRAME_COUNT_INIT;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            x          <= x_n;
            y          <= y_n;
            pat_q      <= pat_n;
            fc_lat     <= fc_lat_n;
            done_cnt   <= done_cnt_n;
            done_pulse <= done_pulse_n;
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer + TW'(1);
        x_n          = x;
        y_n          = y;
        pat_n        = pat_q;
        fc_lat_n     = fc_lat;
        done_cnt_n   = done_cnt;
        done_pulse_n = 1'b0;
        start_frame  = 1'b0;
        case (state)
            IDLE: begin
                timer_n     = '0;
                start_frame = enable;
            end
            FRONT: begin
                if (timer == T_FRONT) begin
                    state_n = LINE;
                    timer_n = '0;
                end
            end
            LINE: begin
                x_n = x + 12'd1;
                if (x == X_LAST) begin
                    x_n     = '0;
                    timer_n = '0;
                    state_n = (y == Y_LAST) ? BACK : HBLANK;
                end
            end
            HBLANK: begin
                if (timer == T_HBLANK) begin
                    state_n = LINE;
                    timer_n = '0;
                    y_n     = y + 12'd1;
                end
            end
            BACK: begin
                if (timer == T_FRONT) begin
                    state_n      = VBLANK;
                    timer_n      = '0;
                    done_cnt_n   = done_cnt + 16'd1;
                    done_pulse_n = 1'b1;
                end
            end
            VBLANK: begin
                if (timer == T_VBLANK) begin
                    timer_n     = '0;
                    state_n     = IDLE;
                    start_frame = enable;
                end
            end
            default: state_n = IDLE;
        endcase
        // Frame-start bookkeeping: coordinates cleared, pattern and count latched.
        if (start_frame) begin
            state_n  = FRONT;
            timer_n  = '0;
            x_n      = '0;
            y_n      = '0;
            pat_n    = pattern_sel;
            fc_lat_n = done_cnt[11:0];
        end
    end

    always_comb begin
        pix = 12'd0;
        case (pat_q)
            2'd0: pix = x;
            2'd1: pix = y;
            2'd2: pix = (x[2] ^ y[2]) ? 12'hFFF : 12'h000;
            2'd3: pix = x + y + fc_lat;
            default: pix = 12'd0;
        endcase
    end

    // Outputs trail the state register by one cycle, so every output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            camera_d    <= '0;
            camera_fval <= 1'b0;
            camera_lval <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            camera_fval <= (state == FRONT) || (state == LINE) ||
                           (state == HBLANK) || (state == BACK);
            camera_lval <= (state == LINE);
            camera_d    <= (state == LINE) ? pix : 12'd0;
            frame_done  <= done_pulse;
            frame_count <= done_cnt;
        end
    end

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// tb/tb_camera_sensor_emulator.sv - directed self-checking bench for camera_sensor_emulator
module tb_camera_sensor_emulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] camera_d;
    logic        camera_fval, camera_lval, frame_done;
    logic [15:0] frame_count;

    logic        enable_w;
    logic [11:0] camera_d_w;
    logic        camera_fval_w, camera_lval_w, frame_done_w;
    logic [15:0] frame_count_w;

    int n_cmp = 0;
    int n_err = 0;
    int w;

    always #5 clk = ~clk;

    camera_sensor_emulator #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3), .V_FRONT(2), .V_BLANK(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .camera_d(camera_d), .camera_fval(camera_fval), .camera_lval(camera_lval),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    camera_sensor_emulator #(
        .H_ACTIVE(1), .V_ACTIVE(1), .H_BLANK(1), .V_FRONT(1), .V_BLANK(1),
        .FRAME_COUNT_INIT(16'hFFFE)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable_w), .pattern_sel(2'd0),
        .camera_d(camera_d_w), .camera_fval(camera_fval_w), .camera_lval(camera_lval_w),
        .frame_done(frame_done_w), .frame_count(frame_count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timeline model of one frame: t=0 is the first fval-high cycle.
    function automatic void exp_at(input int t, input int pat, input int fc,
                                   output logic l, output logic [11:0] d);
        int tt, ln, xx;
        tt = t - 2;
        l  = 1'b0;
        d  = 12'd0;
        if (tt >= 0 && tt < 41) begin
            ln = tt / 11;
            xx = tt % 11;
            if (xx < 8) begin
                l = 1'b1;
                case (pat)
                    0: d = 12'(xx);
                    1: d = 12'(ln);
                    2: d = ((((xx >> 2) ^ (ln >> 2)) & 1) != 0) ? 12'hFFF : 12'h000;
                    default: d = 12'(xx + ln + fc);
                endcase
            end
        end
    endfunction

    task automatic check_frame(input string tag, input int pat, input int fc,
                               input int chg_t, input int chg_sel, input int drop_t,
                               output int waited);
        logic        el;
        logic [11:0] ed;
        waited = 0;
        while (camera_fval !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check({tag, "_start"}, 32'(waited < 200), 32'd1);
        for (int t = 0; t < 45; t++) begin
            exp_at(t, pat, fc, el, ed);
            check($sformatf("%s_fval_t%0d", tag, t), camera_fval, 1);
            check($sformatf("%s_lval_t%0d", tag, t), camera_lval, el);
            check($sformatf("%s_d_t%0d", tag, t), camera_d, ed);
            if (t == chg_t) pattern_sel = 2'(chg_sel);
            if (t == drop_t) enable = 1'b0;
            tick();
        end
        check({tag, "_fval_end"}, camera_fval, 0);
        check({tag, "_done"}, frame_done, 1);
        check({tag, "_count"}, frame_count, 32'(16'(fc + 1)));
        tick();
        check({tag, "_done_once"}, frame_done, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        enable_w    = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) tick();
        check("rst_fval", camera_fval, 0);
        check("rst_lval", camera_lval, 0);
        check("rst_d", camera_d, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);

        // Single frame after idle with enable low.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_fval", camera_fval, 0);
        end
        enable = 1'b1;
        tick();
        check("latency_fval", camera_fval, 0);
        enable = 1'b0;
        check_frame("f1", 0, 0, -1, 0, -1, w);
        check("f1_wait", w, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("f1_idle_fval", camera_fval, 0);
        end
        check("f1_count_hold", frame_count, 1);

        // Single frames with patterns 3, 1 and 2.
        pattern_sel = 2'd3;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_frame("p3", 3, 1, -1, 0, -1, w);
        repeat (8) tick();
        pattern_sel = 2'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_frame("p1", 1, 2, -1, 0, -1, w);
        repeat (8) tick();
        pattern_sel = 2'd2;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_frame("p2", 2, 3, -1, 0, -1, w);
        repeat (8) tick();

        // Continuous run: pattern change mid-frame, then enable dropped mid-frame.
        pattern_sel = 2'd1;
        enable = 1'b1;
        tick();
        check_frame("c1", 1, 4, 20, 0, -1, w);
        check_frame("c2", 0, 5, -1, 0, 10, w);
        check("period", 46 + w - 4, 46);
        check("period_abs", 46 + w, 50);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("c2_stop_fval", camera_fval, 0);
        end

        // Frame counter wrap on the degenerate 1x1 instance.
        enable_w = 1'b1;
        w = 0;
        while (frame_done_w !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("wrap_done1", 32'(w < 50), 1);
        check("wrap_ffff", frame_count_w, 16'hFFFF);
        tick();
        w = 0;
        while (frame_done_w !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("wrap_done2", 32'(w < 50), 1);
        check("wrap_zero", frame_count_w, 0);
        enable_w = 1'b0;

        // Reset asserted mid-line 2, outputs must clear without a clock edge.
        pattern_sel = 2'd0;
        enable = 1'b1;
        w = 0;
        while (camera_fval !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        repeat (27) tick();
        check("mid_lval", camera_lval, 1);
        check("mid_d", camera_d, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_fval", camera_fval, 0);
        check("async_lval", camera_lval, 0);
        check("async_d", camera_d, 0);
        tick();
        tick();
        pattern_sel = 2'd3;
        reset_n = 1'b1;
        check_frame("rs", 3, 0, -1, 0, 0, w);
        check("rs_wait", w, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
